// File: rtl/l2_i_controller.sv
// l2_i_controller: L2 tag/control stage behind the L1 instruction cache.
// The L2 is 2-way set-associative and read-only, with one LRU bit per set.
// A hit returns ready_L2_L1 two cycles after the request is sampled. A miss
// fetches the block from memory, writes it into the victim way and then
// responds.
// Optional build macro: L2_PERF_CNT_EN adds saturating hit/miss counters
// (hit_cnt, miss_cnt). The default build leaves this feature out.
//
// Handshake: read_L1_L2 is a level request that L1 holds until it has seen
// the one-cycle ready_L2_L1 pulse. After responding, the controller waits for
// read_L1_L2 to drop before it accepts another request, so each request gets
// exactly one response. read_L2_MEM is a level request with a stable
// addr_L2_MEM. Memory answers with a one-cycle ready_MEM_L2 pulse, and the
// controller ignores that pulse in any state except ALLOCATE.
module l2_i_controller #(
  parameter int TNUM_2 = 18,
  parameter int INUM_2 = 8
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       read_L1_L2,
  input  logic [TNUM_2-1:0]          tag_L1_L2,
  input  logic [INUM_2-1:0]          index_L1_L2,
  input  logic                       flush,
  input  logic                       ready_MEM_L2,
  output logic                       ready_L2_L1,
  output logic                       hit_L2,
  output logic                       refill_L2,
  output logic                       way_L2,
  output logic [INUM_2-1:0]          index_L2,
  output logic                       read_L2_MEM,
  output logic [TNUM_2+INUM_2-1:0]   addr_L2_MEM,
  output logic [2:0]                 state_dbg
`ifdef L2_PERF_CNT_EN
  ,
  output logic [31:0]                hit_cnt,
  output logic [31:0]                miss_cnt
`endif
);

  localparam int NSETS = 1 << INUM_2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COMPARE   = 3'd1,
    ALLOCATE  = 3'd2,
    REFILL    = 3'd3,
    RESPOND   = 3'd4,
    WAIT_DROP = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [TNUM_2-1:0]   tag_q, tag_d;
  logic [INUM_2-1:0]   idx_q, idx_d;
  logic                way_q, way_d;
  logic                hit_q, hit_d;
  logic                flush_pend_q, flush_pend_d;

  // Per-set state. Tags carry no reset because the valid bits qualify them.
  logic [NSETS-1:0]    valid0_q;
  logic [NSETS-1:0]    valid1_q;
  logic [NSETS-1:0]    lru_q;
  logic [TNUM_2-1:0]   tag0_q [NSETS];
  logic [TNUM_2-1:0]   tag1_q [NSETS];

  // Strobes from the FSM that update the per-set arrays.
  logic                flush_apply;
  logic                fill_en;
  logic                lru_en;

  // Results of the lookup for the latched set.
  logic                hit0;
  logic                hit1;
  logic                victim;
  logic                cmp_hit;
  logic                cmp_miss;

  // Compare both ways of the latched set and choose the way to replace.
  always_comb begin
    hit0 = valid0_q[idx_q] && (tag0_q[idx_q] == tag_q);
    hit1 = valid1_q[idx_q] && (tag1_q[idx_q] == tag_q);
    if (!valid0_q[idx_q]) begin
      victim = 1'b0;
    end else if (!valid1_q[idx_q]) begin
      victim = 1'b1;
    end else begin
      victim = lru_q[idx_q];
    end
    cmp_hit  = (state_q == COMPARE) && (hit0 || hit1);
    cmp_miss = (state_q == COMPARE) && !(hit0 || hit1);
  end

  // Next-state logic and the array update strobes.
  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    idx_d        = idx_q;
    way_d        = way_q;
    hit_d        = hit_q;
    flush_pend_d = flush_pend_q | flush;
    flush_apply  = 1'b0;
    fill_en      = 1'b0;
    lru_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (read_L1_L2) begin
          // A request takes priority, so a concurrent flush stays pending.
          tag_d   = tag_L1_L2;
          idx_d   = index_L1_L2;
          state_d = COMPARE;
        end else if (flush || flush_pend_q) begin
          flush_apply  = 1'b1;
          flush_pend_d = 1'b0;
        end
      end
      COMPARE: begin
        if (hit0 || hit1) begin
          way_d   = !hit0;
          hit_d   = 1'b1;
          state_d = RESPOND;
        end else begin
          way_d   = victim;
          hit_d   = 1'b0;
          state_d = ALLOCATE;
        end
      end
      ALLOCATE: begin
        if (ready_MEM_L2) begin
          state_d = REFILL;
        end
      end
      REFILL: begin
        fill_en = 1'b1;
        hit_d   = 1'b0;
        state_d = RESPOND;
      end
      RESPOND: begin
        lru_en  = 1'b1;
        state_d = WAIT_DROP;
      end
      WAIT_DROP: begin
        if (!read_L1_L2) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers. The asynchronous reset drops any memory request at once.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      tag_q        <= '0;
      idx_q        <= '0;
      way_q        <= 1'b0;
      hit_q        <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      idx_q        <= idx_d;
      way_q        <= way_d;
      hit_q        <= hit_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Valid and LRU bits. A flush clears every set in one cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      valid0_q <= '0;
      valid1_q <= '0;
      lru_q    <= '0;
    end else if (flush_apply) begin
      valid0_q <= '0;
      valid1_q <= '0;
      lru_q    <= '0;
    end else begin
      if (fill_en) begin
        if (way_q) begin
          valid1_q[idx_q] <= 1'b1;
        end else begin
          valid0_q[idx_q] <= 1'b1;
        end
      end
      if (lru_en) begin
        lru_q[idx_q] <= ~way_q;
      end
    end
  end

  // Tag array write on refill into the chosen victim way.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      if (way_q) begin
        tag1_q[idx_q] <= tag_q;
      end else begin
        tag0_q[idx_q] <= tag_q;
      end
    end
  end

`ifdef L2_PERF_CNT_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // Saturating lookup counters, cleared by reset and by an applied flush.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (flush_apply) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (cmp_hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (cmp_miss && (miss_cnt_q != 32'hFFFF_FFFF)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  // The lookup outcome is used only by the counters. Without them it is
  // folded in here so the signals still have a load.
  logic unused_cmp;
  assign unused_cmp = cmp_hit ^ cmp_miss;
`endif

  // Outputs are decoded from registered state, so they do not glitch.
  assign ready_L2_L1 = (state_q == RESPOND);
  assign refill_L2   = (state_q == REFILL);
  assign read_L2_MEM = (state_q == ALLOCATE);
  assign hit_L2      = hit_q;
  assign way_L2      = way_q;
  assign index_L2    = idx_q;
  assign addr_L2_MEM = {tag_q, idx_q};
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_l2_i_controller.sv
// Testbench for l2_i_controller. Directed cases cover cold miss, hit,
// way1 fill with LRU, the L1 handshake, flush and reset during ALLOCATE.
// These are followed by randomized requests. Expected responses come from a
// behavioural cache model and go into queues that a negedge monitor drains.
module tb_l2_i_controller;
  localparam int TW = 18;
  localparam int IW = 8;
  localparam int NS = 256;

  logic          clk = 1'b0;
  logic          nrst;
  logic          read_L1_L2;
  logic [TW-1:0] tag_L1_L2;
  logic [IW-1:0] index_L1_L2;
  logic          flush;
  logic          ready_MEM_L2;
  logic          ready_L2_L1;
  logic          hit_L2;
  logic          refill_L2;
  logic          way_L2;
  logic [IW-1:0] index_L2;
  logic          read_L2_MEM;
  logic [25:0]   addr_L2_MEM;
  logic [2:0]    state_dbg;
`ifdef L2_PERF_CNT_EN
  logic [31:0]   hit_cnt;
  logic [31:0]   miss_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Scoreboard queues: responses {hit, way, idx}, memory addresses, refills {way, idx}.
  logic [9:0]  exp_q[$];
  logic [25:0] mem_q[$];
  logic [8:0]  fill_q[$];

  // Reference cache model.
  bit            m_valid [2][NS];
  logic [TW-1:0] m_tag   [2][NS];
  bit            m_lru   [NS];
  bit            m_pend;
  int unsigned   m_hits;
  int unsigned   m_misses;

  l2_i_controller #(.TNUM_2(TW), .INUM_2(IW)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .read_L1_L2  (read_L1_L2),
    .tag_L1_L2   (tag_L1_L2),
    .index_L1_L2 (index_L1_L2),
    .flush       (flush),
    .ready_MEM_L2(ready_MEM_L2),
    .ready_L2_L1 (ready_L2_L1),
    .hit_L2      (hit_L2),
    .refill_L2   (refill_L2),
    .way_L2      (way_L2),
    .index_L2    (index_L2),
    .read_L2_MEM (read_L2_MEM),
    .addr_L2_MEM (addr_L2_MEM),
    .state_dbg   (state_dbg)
`ifdef L2_PERF_CNT_EN
    ,
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt)
`endif
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event seen with no expectation queued", name);
  endtask

  task automatic model_clear();
    for (int w = 0; w < 2; w++) begin
      for (int s = 0; s < NS; s++) begin
        m_valid[w][s] = 1'b0;
      end
    end
    for (int s = 0; s < NS; s++) begin
      m_lru[s] = 1'b0;
    end
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic model_lookup(input logic [TW-1:0] t, input logic [IW-1:0] i,
                              output bit hit, output bit way);
    if (m_valid[0][i] && m_tag[0][i] == t) begin
      hit = 1'b1; way = 1'b0;
    end else if (m_valid[1][i] && m_tag[1][i] == t) begin
      hit = 1'b1; way = 1'b1;
    end else begin
      hit = 1'b0;
      if (!m_valid[0][i])      way = 1'b0;
      else if (!m_valid[1][i]) way = 1'b1;
      else                     way = m_lru[i];
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  // Monitor: pops and compares whenever the DUT presents an event.
  logic        prev_mem = 1'b0;
  logic [25:0] cur_addr = '0;
  always @(negedge clk) begin
    if (nrst) begin
      if (read_L2_MEM && !prev_mem) begin
        if (mem_q.size() == 0) fail_evt("unexpected_mem_req");
        else begin
          cur_addr = mem_q.pop_front();
          chk("mem_addr", addr_L2_MEM, cur_addr);
        end
      end else if (read_L2_MEM) begin
        chk("mem_addr_stable", addr_L2_MEM, cur_addr);
      end
      if (refill_L2) begin
        if (fill_q.size() == 0) fail_evt("unexpected_refill");
        else begin
          logic [8:0] f;
          f = fill_q.pop_front();
          chk("refill_way", way_L2, f[8]);
          chk("refill_index", index_L2, f[7:0]);
        end
      end
      if (ready_L2_L1) begin
        if (exp_q.size() == 0) fail_evt("unexpected_ready");
        else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          chk("resp_hit", hit_L2, e[9]);
          chk("resp_way", way_L2, e[8]);
          chk("resp_index", index_L2, e[7:0]);
        end
      end
    end
    prev_mem = nrst ? read_L2_MEM : 1'b0;
  end

  // One L1 request with memory emulation. fmode: 1 = flush with the request,
  // 2 = flush when the outcome is first visible.
  task automatic do_req(input logic [TW-1:0] t, input logic [IW-1:0] i, input int delay,
                        input int hold, input int fmode, input bit stray);
    bit h, w;
    int cyc;
    model_lookup(t, i, h, w);
    exp_q.push_back({h, w, i});
    if (!h) begin
      mem_q.push_back({t, i});
      fill_q.push_back({w, i});
      m_valid[w][i] = 1'b1;
      m_tag[w][i]   = t;
      m_misses++;
    end else begin
      m_hits++;
    end
    m_lru[i] = ~w;
    if (fmode != 0) m_pend = 1'b1;

    @(negedge clk);
    read_L1_L2  = 1'b1;
    tag_L1_L2   = t;
    index_L1_L2 = i;
    if (fmode == 1) fork pulse_flush(); join_none
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!ready_L2_L1 && !read_L2_MEM && cyc < 20);
    if (fmode == 2) fork pulse_flush(); join_none
    if (read_L2_MEM) begin
      chk("miss_path", 1, !h);
      chk("mem_latency", cyc, 2);
      repeat (delay) @(negedge clk);
      ready_MEM_L2 = 1'b1;
      @(negedge clk);
      ready_MEM_L2 = 1'b0;
      cyc = 1;
      while (!ready_L2_L1 && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      chk("miss_resp_latency", cyc, 2);
    end else if (ready_L2_L1) begin
      chk("miss_path", 0, !h);
      chk("hit_latency", cyc, 2);
    end else begin
      fail_evt("req_timeout");
    end
    repeat (hold) begin
      @(negedge clk);
      ready_MEM_L2 = stray ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    @(negedge clk);
    ready_MEM_L2 = 1'b0;
    read_L1_L2   = 1'b0;
    tag_L1_L2    = TW'($urandom);
    index_L1_L2  = IW'($urandom);
    repeat (2) @(negedge clk);
    if (m_pend) begin
      model_clear();
      m_pend = 1'b0;
    end
  endtask

  task automatic idle_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_clear();
  endtask

  task automatic rst_mid_alloc(input logic [TW-1:0] t, input logic [IW-1:0] i);
    int cyc;
    mem_q.push_back({t, i});
    @(negedge clk);
    read_L1_L2  = 1'b1;
    tag_L1_L2   = t;
    index_L1_L2 = i;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!read_L2_MEM && cyc < 20);
    chk("rst_alloc_reached", read_L2_MEM, 1);
    #2 nrst = 1'b0;
    #1;
    chk("rst_mem_drop", read_L2_MEM, 0);
    chk("rst_addr_clear", addr_L2_MEM, 0);
    read_L1_L2 = 1'b0;
    model_clear();
    m_pend = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    mem_q.delete();
  endtask

  logic [TW-1:0] tag_pool [4];
  logic [IW-1:0] idx_pool [3];

  initial begin
    int r, fm;
    logic [TW-1:0] t;
    logic [IW-1:0] i;
    tag_pool = '{18'h2A5F3, 18'h00001, 18'h3FFFF, 18'h12345};
    idx_pool = '{8'h11, 8'h00, 8'hFF};
    model_clear();
    m_pend       = 1'b0;
    nrst         = 1'b0;
    read_L1_L2   = 1'b0;
    tag_L1_L2    = '0;
    index_L1_L2  = '0;
    flush        = 1'b0;
    ready_MEM_L2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", ready_L2_L1, 0);
    chk("reset_hit", hit_L2, 0);
    chk("reset_refill", refill_L2, 0);
    chk("reset_way", way_L2, 0);
    chk("reset_index", index_L2, 0);
    chk("reset_mem_req", read_L2_MEM, 0);
    chk("reset_addr", addr_L2_MEM, 0);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    do_req(18'h2A5F3, 8'h11, 3, 0, 0, 1'b0);   // cold miss, way0
    do_req(18'h2A5F3, 8'h11, 0, 0, 0, 1'b0);   // hit way0
    do_req(18'h00001, 8'h11, 1, 0, 0, 1'b0);   // miss fills way1
    do_req(18'h2A5F3, 8'h11, 0, 0, 0, 1'b0);   // hit, lru -> way1
    do_req(18'h3FFFF, 8'h11, 2, 0, 0, 1'b0);   // miss, victim way1
    do_req(18'h2A5F3, 8'h11, 0, 10, 0, 1'b1);  // long hold, stray memory pulses
    do_req(18'h0BEEF, 8'h22, 4, 0, 2, 1'b0);   // flush during ALLOCATE
    do_req(18'h2A5F3, 8'h11, 0, 0, 0, 1'b0);   // now misses after flush
    do_req(18'h2A5F3, 8'h11, 0, 1, 1, 1'b0);   // flush with request: hit first
    do_req(18'h2A5F3, 8'h11, 1, 0, 0, 1'b0);   // then miss
    idle_flush();
    do_req(18'h2A5F3, 8'h11, 0, 0, 0, 1'b0);   // miss after idle flush
    do_req(18'h00001, 8'h33, 2, 0, 0, 1'b0);
    rst_mid_alloc(18'h00005, 8'h33);
    do_req(18'h00001, 8'h33, 1, 0, 0, 1'b0);   // previously filled, misses

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 4);
      t = (r == 4) ? TW'($urandom) : tag_pool[r];
      r = $urandom_range(0, 3);
      i = (r == 3) ? IW'($urandom) : idx_pool[r];
      r = $urandom_range(0, 9);
      fm = (r == 0) ? 1 : ((r == 1) ? 2 : 0);
      if ($urandom_range(0, 9) == 0) idle_flush();
      do_req(t, i, $urandom_range(0, 5), $urandom_range(0, 3), fm, 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    chk("resp_queue_drained", exp_q.size(), 0);
    chk("mem_queue_drained", mem_q.size(), 0);
    chk("fill_queue_drained", fill_q.size(), 0);
`ifdef L2_PERF_CNT_EN
    chk("hit_cnt", hit_cnt, m_hits);
    chk("miss_cnt", miss_cnt, m_misses);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/l2_i_controller.md
Name: l2_i_controller

Overview:
- L2 tag/control stage directly downstream of the L1 instruction cache controller.
- Consumes the L1 miss request (read_L1_L2, tag_L1_L2, index_L1_L2) and returns a one-cycle ready_L2_L1 pulse when the block is available in L2.
- 2-way set-associative, read-only, one LRU bit per set.
- On an L2 miss it fetches the 64-byte block from main memory, then drives the L2 data-array refill strobe.

Parameters:
- TNUM_2, 18, L2 tag bits.
- INUM_2, 8, L2 index bits (2^INUM_2 sets). TNUM_2 + INUM_2 = 26 is the block address width (byte offset is 6 bits).

Ports:
- clk  input  1  clock, rising edge.
- nrst  input  1  asynchronous active-low reset.
- read_L1_L2  input  1  L1 miss request; held high until ready_L2_L1 has been seen.
- tag_L1_L2  input  TNUM_2  request tag.
- index_L1_L2  input  INUM_2  request set index.
- flush  input  1  invalidate all lines.
- ready_MEM_L2  input  1  memory block-returned pulse.
- ready_L2_L1  output  1  one-cycle response pulse to L1.
- hit_L2  output  1  registered lookup result, valid during RESPOND.
- refill_L2  output  1  L2 data-array write strobe.
- way_L2  output  1  way being accessed or refilled.
- index_L2  output  INUM_2  latched set index for the L2 data array.
- read_L2_MEM  output  1  memory read request.
- addr_L2_MEM  output  26  block address {tag, index}.

Behaviour:
- Reset (async, nrst=0):
  - state=IDLE; all outputs 0.
  - All valid bits and LRU bits cleared.
  - Reset mid-miss abandons the memory request; read_L2_MEM drops immediately.
- States: IDLE, COMPARE, ALLOCATE, REFILL, RESPOND, WAIT_DROP.
- IDLE:
  - If read_L1_L2=1, latch tag/index → COMPARE.
  - Else if flush (or flush pending), clear all valid and LRU bits in one cycle; stay IDLE.
- COMPARE: hit = valid[w][idx] && tag[w][idx]==tag_q, checked for both ways.
  - Hit → RESPOND with way_L2=hit way, hit_L2=1.
  - Miss → pick victim, set way_L2=victim → ALLOCATE.
- Victim choice: first invalid way (way0 before way1); if both valid, victim = lru[idx].
- ALLOCATE:
  - read_L2_MEM=1, addr_L2_MEM={tag_q, idx_q}, held stable.
  - On ready_MEM_L2=1 → REFILL.
- REFILL: one cycle.
  - refill_L2=1.
  - Write tag_q into the victim way, set its valid bit.
  - → RESPOND with hit_L2=0.
- RESPOND: one cycle.
  - ready_L2_L1=1.
  - lru[idx] = ~way_L2.
  - → WAIT_DROP.
- WAIT_DROP: stay until read_L1_L2=0, then → IDLE. This guarantees one response per request.
- Latency, counted from the sampling edge in IDLE as cycle 0:
  - Hit: ready_L2_L1 high in cycle 2.
  - Miss: read_L2_MEM rises in cycle 2; ready_L2_L1 high 2 cycles after the edge that samples ready_MEM_L2.
- Flush outside IDLE: latched in flush_pend and applied on the next IDLE cycle with read_L1_L2=0.
- Request vs flush in the same IDLE cycle: the request wins; flush stays pending.
- ready_MEM_L2 outside ALLOCATE is ignored.
- Tag/index inputs are ignored after latching.

Optional Feature:
- Macro: L2_PERF_CNT_EN.
- When defined:
  - Adds outputs hit_cnt[31:0] and miss_cnt[31:0].
  - Each counter increments once per COMPARE outcome and saturates at 0xFFFF_FFFF.
  - Both are cleared by reset and by an applied flush.
- When undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Cold miss: tag=0x2A5F3, idx=0x11 → read_L2_MEM=1 with addr_L2_MEM=0x2A5F311 in cycle 2; ready_MEM_L2 pulse → refill_L2=1 with way_L2=0 one cycle later, then ready_L2_L1 pulse, hit_L2=0.
- Hit: repeat the same address after read_L1_L2 drops → ready_L2_L1 in cycle 2, hit_L2=1, way_L2=0, read_L2_MEM stays 0.
- Way1 fill and LRU:
  - Miss tag=0x00001 idx=0x11 → fills way1.
  - Hit 0x2A5F3 → lru=1.
  - Miss tag=0x3FFFF idx=0x11 → victim way1, refill_L2 with way_L2=1.
- Handshake: hold read_L1_L2 high 10 cycles after ready_L2_L1 → exactly one ready_L2_L1 pulse, no second lookup.
- Flush:
  - Assert flush during ALLOCATE → miss completes normally.
  - Flush is applied in the next idle cycle.
  - Prior hit address now misses (read_L2_MEM=1).
- Reset mid-ALLOCATE: nrst=0 → read_L2_MEM=0 immediately; after release, the previously filled address misses.
